bru_branch_ctl: RTL
===================

# bru_branch_ctl

Branch-ID allocator and branch-flush scheduler between ISU, BRU and WBU. Hands out `branch_id` tags to branches as ISU issues them and retires them in order as BRU results arrive. For a taken branch or a misaligned target, it waits for the delay-slot instruction to commit, then drives one flush/redirect handshake carrying the kind, branch_id and new PC. Younger tags are squashed when that flush completes.

## Interface
- `NUM_IDS`, 4: number of branch tags in flight; power of two, ≥2.
- `ID_W`, 2: tag width, log2(NUM_IDS).
- `EXC_VEC`, 32'hBFC00380: redirect PC for exception flushes.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `alloc_req`  in  1  ISU requests a tag for the branch it is issuing.
- `alloc_grant`  out  1  tag granted this cycle.
- `alloc_id`  out  ID_W  granted tag; equals the tail pointer.
- `res_valid`  in  1  BRU result valid.
- `res_ready`  out  1  result accepted.
- `res_branch_id`  in  ID_W  tag of the resolving branch.
- `res_is_taken`  in  1  branch taken.
- `res_target`  in  32  branch target.
- `ds_commit`  in  1  delay-slot instruction of the pending branch committed (one-cycle pulse from WBU).
- `flush_valid`  out  1  flush request to all FUs and ISU.
- `flush_ready`  in  1  flush accepted.
- `flush_kind`  out  2  0 none, 1 branch, 2 exception.
- `flush_branch_id`  out  ID_W  tag of the flushing branch.
- `flush_pc`  out  32  redirect PC for IFU.
- `outstanding`  out  ID_W+1  number of live tags.
- `err`  out  1  sticky protocol-error flag.

## Operation
- State: circular `head` (oldest live tag), `tail` (next free tag), `count`, FSM `{IDLE, WAIT_DS, FLUSH}`, plus latched kind, id and pc.
- `alloc_grant = alloc_req & (state==IDLE) & (count<NUM_IDS)`. On a grant, tail increments and wraps mod NUM_IDS.
- `res_ready = (state==IDLE)`. A result is accepted on `res_valid & res_ready`.
  - If `count==0` or `res_branch_id!=head`: drop the result, set `err`, change no other state.
  - Otherwise retire head: head+1, count-1.
  - Misaligned (`res_is_taken & |res_target[1:0]`): latch kind=2, pc=EXC_VEC, id=head. Go WAIT_DS.
  - Taken and aligned: latch kind=1, pc=res_target, id=head. Go WAIT_DS.
  - Not taken: stay IDLE.
- A grant and a retire in the same cycle apply together; count is net unchanged. A tag granted in the same cycle as a taken resolve is live and is squashed by the later flush.
- WAIT_DS: allocations and results are blocked. `ds_commit` moves to FLUSH. `ds_commit` in IDLE or FLUSH is ignored.
- FLUSH: `flush_valid=1`, with kind, id and pc held stable until `flush_ready`. On the handshake: tail←head, count←0 (all younger tags squashed), go IDLE.
- Outside FLUSH: `flush_valid=0`, `flush_kind=0`; id and pc hold their last values.
- `err` clears only on reset.

## Timing
- Reset (`rst`=0, asynchronous): head=tail=0, count=0, state IDLE, latched kind, id and pc all 0. All outputs are 0 except `res_ready`=1 and `alloc_id`=0.
- `alloc_grant`, `alloc_id` and `res_ready` are combinational from registered state. `alloc_grant` also depends on `alloc_req`. No other combinational input-to-output paths.
- Taken result accepted at edge N → WAIT_DS from N. `ds_commit` sampled at edge M>N → `flush_valid` high in cycle M+1. Minimum taken-result-to-flush latency is 2 cycles.
- `flush_ready` held high → flush completes in 1 cycle. `res_ready` and `alloc_grant` become possible again in the next cycle.
- `rst` asserted mid-WAIT_DS or mid-FLUSH: `flush_valid` drops immediately (asynchronously); no partial flush is retained.
- Full (`count==NUM_IDS`): grant blocked. A same-cycle retire does not unblock it; the grant comes the next cycle.

## Test plan
- Reset, then 5 `alloc_req` cycles with no results → grants for ids 0,1,2,3. Fifth request not granted; `outstanding`=4.
- Allocate ids 0..2; results id0 not-taken, id1 taken with target 0x80001000; `ds_commit` 3 cycles later; `flush_ready`=1 → `flush_valid` for 1 cycle with kind=1, id=1, pc=0x80001000. Afterwards `outstanding`=0 and the next `alloc_id`=2.
- Taken result with target 0x80001002 → after `ds_commit`, kind=2, pc=0xBFC00380.
- In FLUSH, hold `flush_ready`=0 for 4 cycles → `flush_valid` and payload stable for all 4. `res_ready`=0 and no grants throughout.
- Result with id≠head (allocate 0,1; resolve id1 first) → `err`=1 and stays set; `outstanding` stays 2.
- With 3 tags live in IDLE, `alloc_req` and a not-taken resolve of the head in the same cycle → `outstanding` stays 3 and tail advances. Repeat across the 3→0 wrap; ids continue 3,0,1.

Source files
------------

// File: rtl/bru_branch_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bru_branch_ctl_if
//  Description : Handshake bundle between ISU/BRU/WBU and the branch-ID
//                allocator / flush scheduler. master = requesting side,
//                slave = bru_branch_ctl.
//  Revision    : 1.0  initial release
// ============================================================================
interface bru_branch_ctl_if #(
  parameter int ID_W = 2
);
  logic            alloc_req;
  logic            alloc_grant;
  logic [ID_W-1:0] alloc_id;

  logic            res_valid;
  logic            res_ready;
  logic [ID_W-1:0] res_branch_id;
  logic            res_is_taken;
  logic [31:0]     res_target;

  logic            ds_commit;

  logic            flush_valid;
  logic            flush_ready;
  logic [1:0]      flush_kind;
  logic [ID_W-1:0] flush_branch_id;
  logic [31:0]     flush_pc;

  logic [ID_W:0]   outstanding;
  logic            err;

  modport master (
    output alloc_req, res_valid, res_branch_id, res_is_taken, res_target,
           ds_commit, flush_ready,
    input  alloc_grant, alloc_id, res_ready, flush_valid, flush_kind,
           flush_branch_id, flush_pc, outstanding, err
  );

  modport slave (
    input  alloc_req, res_valid, res_branch_id, res_is_taken, res_target,
           ds_commit, flush_ready,
    output alloc_grant, alloc_id, res_ready, flush_valid, flush_kind,
           flush_branch_id, flush_pc, outstanding, err
  );
endinterface
`default_nettype wire

// File: rtl/bru_branch_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : bru_branch_ctl
//  Description : Branch-tag allocator and flush scheduler. Tags are handed
//                out in order, retired in order by BRU results, and a taken
//                or misaligned branch triggers a flush/redirect once its
//                delay slot has committed.
//  Revision    : 1.0  initial release
// ============================================================================
module bru_branch_ctl #(
  parameter int          NUM_IDS = 4,
  parameter int          ID_W    = 2,
  parameter logic [31:0] EXC_VEC = 32'hBFC00380
) (
  input  wire logic         clk,
  input  wire logic         rst,   // asynchronous, active-low
  bru_branch_ctl_if.slave   bus
);

  localparam logic [ID_W:0] C_NUM_IDS   = (ID_W+1)'(NUM_IDS);
  localparam logic [1:0]    C_KIND_NONE = 2'd0;
  localparam logic [1:0]    C_KIND_BR   = 2'd1;
  localparam logic [1:0]    C_KIND_EXC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_DS = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_head;
  logic [ID_W-1:0] r_tail;
  logic [ID_W:0]   r_count;
  logic [1:0]      r_kind;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_pc;
  logic            r_err;

  logic w_idle;
  logic w_grant;
  logic w_res_acc;
  logic w_res_ok;
  logic w_res_bad;
  logic w_misaligned;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_grant      = bus.alloc_req & w_idle & (r_count < C_NUM_IDS);
  assign w_res_acc    = bus.res_valid & w_idle;
  // A result is only legal for the oldest live tag.
  assign w_res_ok     = w_res_acc & (r_count != '0) & (bus.res_branch_id == r_head);
  assign w_res_bad    = w_res_acc & ~w_res_ok;
  assign w_misaligned = bus.res_is_taken & (|bus.res_target[1:0]);

  assign bus.alloc_grant     = w_grant;
  assign bus.alloc_id        = r_tail;
  assign bus.res_ready       = w_idle;
  assign bus.flush_valid     = (r_state == ST_FLUSH);
  assign bus.flush_kind      = (r_state == ST_FLUSH) ? r_kind : C_KIND_NONE;
  assign bus.flush_branch_id = r_id;
  assign bus.flush_pc        = r_pc;
  assign bus.outstanding     = r_count;
  assign bus.err             = r_err;

  // Tag bookkeeping and the resolve -> delay-slot -> flush sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_kind  <= C_KIND_NONE;
      r_id    <= '0;
      r_pc    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_tail <= r_tail + 1'b1;
          end
          if (w_res_ok) begin
            r_head <= r_head + 1'b1;
          end
          // Grant and retire in one cycle cancel out on the count.
          case ({w_grant, w_res_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
          if (w_res_bad) begin
            r_err <= 1'b1;
          end
          if (w_res_ok && bus.res_is_taken) begin
            r_id    <= r_head;
            r_state <= ST_WAIT_DS;
            if (w_misaligned) begin
              r_kind <= C_KIND_EXC;
              r_pc   <= EXC_VEC;
            end else begin
              r_kind <= C_KIND_BR;
              r_pc   <= bus.res_target;
            end
          end
        end
        ST_WAIT_DS: begin
          if (bus.ds_commit) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Completed flush squashes every tag younger than the branch.
          if (bus.flush_ready) begin
            r_tail  <= r_head;
            r_count <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
